// File: rtl/vdp_access_sched.sv
// vdp_access_sched: arbitrates a shared VDP memory port between the CPU and an
// auxiliary requester (video fetch / DMA). Each grant produces a fixed-length
// access strobe, then an optional recovery gap. Ties between the two
// requesters are broken round-robin.
module vdp_access_sched #(
    parameter int WAIT_CYCLES = 4,   // strobe length in clk1 cycles, 1..15
    parameter int HOLD_CYCLES = 2    // recovery gap after each access, 0..15
) (
    input  logic clk1,
    input  logic n_clr1,
    input  logic req_cpu,
    input  logic req_aux,
    output logic gnt_cpu,
    output logic gnt_aux,
    output logic strobe,
    output logic done,
    output logic busy,
    output logic cpu_ready
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Counter load values; a zero-length gap skips RECOVER entirely.
    localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] HOLD_LD  = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
    localparam bit         HAS_HOLD = (HOLD_CYCLES > 0);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_aux_q, last_aux_d;
    logic       gnt_cpu_q, gnt_cpu_d;
    logic       gnt_aux_q, gnt_aux_d;
    logic       strobe_q, strobe_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       pick_aux;

    // Next-state, counter, ownership and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_aux_d = last_aux_q;
        gnt_cpu_d  = gnt_cpu_q;
        gnt_aux_d  = gnt_aux_q;
        pick_aux   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_cpu || req_aux) begin
                    // Aux wins alone, or on a tie when the CPU owned the port last.
                    pick_aux   = req_aux && (!req_cpu || !last_aux_q);
                    state_d    = ST_ACCESS;
                    cnt_d      = WAIT_LD;
                    last_aux_d = pick_aux;
                    gnt_aux_d  = pick_aux;
                    gnt_cpu_d  = !pick_aux;
                end
            end
            ST_ACCESS: begin
                // The access always runs to completion; requests are not sampled.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    gnt_cpu_d = 1'b0;
                    gnt_aux_d = 1'b0;
                    if (HAS_HOLD) begin
                        state_d = ST_RECOVER;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
            end
            ST_RECOVER: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = 4'd0;
                gnt_cpu_d = 1'b0;
                gnt_aux_d = 1'b0;
            end
        endcase

        // Outputs are decoded from the next state so they are flop outputs.
        strobe_d = (state_d == ST_ACCESS);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_ACCESS) && (cnt_d == 4'd0);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk1 or negedge n_clr1) begin
        if (!n_clr1) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            last_aux_q <= 1'b1;
            gnt_cpu_q  <= 1'b0;
            gnt_aux_q  <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_aux_q <= last_aux_d;
            gnt_cpu_q  <= gnt_cpu_d;
            gnt_aux_q  <= gnt_aux_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt_cpu = gnt_cpu_q;
    assign gnt_aux = gnt_aux_q;
    assign strobe  = strobe_q;
    assign done    = done_q;
    assign busy    = busy_q;

    // The CPU is released when it is not asking, or on the last cycle of its access.
    assign cpu_ready = !req_cpu | (gnt_cpu_q & done_q);

endmodule

// File: doc/vdp_access_sched.md
VDP_ACCESS_SCHED -- requirements
Module: vdp_access_sched

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 4, giving the access strobe length in clk1 cycles (legal range 1..15).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, giving the recovery gap after each access in clk1 cycles (legal range 0..15).
REQ-003 SHALL have port clk1, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-004 SHALL have port n_clr1, input, 1 bit: the reset, asynchronous, active-low.
REQ-005 SHALL have port req_cpu, input, 1 bit: CPU access request, level, held until done.
REQ-006 SHALL have port req_aux, input, 1 bit: auxiliary (video fetch/DMA) access request, level, held until done.
REQ-007 SHALL have port gnt_cpu, output, 1 bit: CPU owns the shared port.
REQ-008 SHALL have port gnt_aux, output, 1 bit: auxiliary requester owns the shared port.
REQ-009 SHALL have port strobe, output, 1 bit: access strobe to the shared device, high during ACCESS.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse on the last ACCESS cycle.
REQ-011 SHALL have port busy, output, 1 bit: high in ACCESS or RECOVER.
REQ-012 SHALL have port cpu_ready, output, 1 bit: CPU wait-state line; low stalls the CPU.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, ACCESS and RECOVER, plus a 4-bit down-counter cnt and a last-owner flag last_aux.
REQ-014 SHALL, in IDLE with exactly one request high, move to ACCESS on the next edge, assert that requester's grant, and load cnt=WAIT_CYCLES-1.
REQ-015 SHALL, in IDLE with both requests high, grant req_aux if last_aux=0, otherwise grant req_cpu (round-robin).
REQ-016 SHALL update last_aux on each grant (1 for aux, 0 for cpu).
REQ-017 SHALL, in ACCESS, decrement cnt each edge while cnt!=0.
REQ-018 SHALL, in ACCESS with cnt==0, assert done for that cycle only, then on the next edge go to RECOVER with cnt=HOLD_CYCLES-1, or directly to IDLE if HOLD_CYCLES=0.
REQ-019 SHALL keep strobe high for exactly WAIT_CYCLES consecutive cycles per access.
REQ-020 SHALL never assert gnt_cpu and gnt_aux simultaneously.
REQ-021 SHALL hold the grant constant through the whole of ACCESS and drop it on the ACCESS-exit edge.
REQ-022 SHALL, in RECOVER, decrement cnt and go to IDLE on the edge where cnt==0; requests are ignored during RECOVER.
REQ-023 SHALL complete a started access to full length even if its request is deasserted mid-ACCESS (no abort).
REQ-024 SHALL register all outputs except cpu_ready.
REQ-025 SHALL compute cpu_ready = !req_cpu | (gnt_cpu & done), combinationally.
REQ-026 SHALL give a back-to-back period of WAIT_CYCLES+HOLD_CYCLES+1 cycles under continuous requests (7 cycles with defaults).
REQ-027 SHALL alternate grants under continuous requests from both requesters.

Reset
REQ-028 SHALL, while n_clr1=0, immediately force state=IDLE, cnt=0, last_aux=1, and gnt_cpu=gnt_aux=strobe=done=busy=0, independent of clk1.
REQ-029 SHALL abandon an access interrupted by reset mid-ACCESS, with no done pulse.
REQ-030 SHALL let the first arbitration after reset favour the CPU.
REQ-031 SHALL make the first grant possible on the first clk1 edge after n_clr1 rises.

Verification
REQ-032 SHALL cover a single CPU request: req_cpu=1 before edge 0 -> gnt_cpu=strobe=busy=1 after edge 0; done=1 and cpu_ready=1 only between edges 3 and 4; gnt=0 after edge 4; busy=0 after edge 6.
REQ-033 SHALL cover a simultaneous first request: req_cpu=req_aux=1 right after reset -> gnt_cpu first, gnt_aux 7 cycles later, then alternating cpu/aux/cpu.
REQ-034 SHALL cover an early request drop: req_aux dropped after edge 1 of its access -> strobe still high 4 cycles and done still pulses once.
REQ-035 SHALL cover reset mid-access: n_clr1 low while cnt=2 -> all outputs 0 within the same cycle, no done pulse; after release with req_cpu=1 -> gnt_cpu on the first edge.
REQ-036 SHALL cover the parameter corners: WAIT_CYCLES=1, HOLD_CYCLES=0 -> strobe and done coincide for 1 cycle, back-to-back period 2 cycles, busy never high in RECOVER.
REQ-037 SHALL check, in every scenario, that gnt_cpu&gnt_aux is never 1 and that strobe=1 iff state=ACCESS.
